// File: rtl/tempo_scheduler_pkg.sv
// Shared definitions for the tempo scheduler: state encoding, step period
// table and the tick rate that makes up one second.
package tempo_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int TICKS_PER_SEC = 100;
  localparam int STEP_W        = 6;
  localparam int SUB_W         = 7;

  // Ticks per falling-tile step for each speed setting.
  function automatic logic [STEP_W-1:0] step_period(input logic [1:0] spd);
    logic [STEP_W-1:0] p;
    case (spd)
      2'b00:   p = 6'd50;
      2'b01:   p = 6'd25;
      2'b10:   p = 6'd10;
      default: p = 6'd5;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tempo_scheduler_tick_div.sv
// Free-running divider: pulses tick for one cycle each time the count
// wraps from TICK_DIV-1 back to 0.
module tick_div #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == LAST);
    cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/tempo_scheduler.sv
// Game tempo controller: turns the 100 Hz tick into tile steps and a
// seconds countdown, with start/pause/stop control.
//
// state | meaning
// IDLE  | waiting for start, counters cleared
// RUN   | counting ticks into steps and seconds
// PAUSE | everything frozen until pause again
// DONE  | time ran out, waiting for a restart
module tempo_scheduler
  import tempo_scheduler_pkg::*;
#(
  parameter int TICK_DIV = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [1:0] speed,
  input  logic [7:0] game_len,
  output logic       tick,
  output logic       step,
  output logic [7:0] time_left,
  output logic [1:0] state,
  output logic       done
);

  state_e            state_q, state_d;
  logic [7:0]        time_left_q, time_left_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
  logic [1:0]        speed_q, speed_d;
  logic              step_q, step_d;
  logic              done_q, done_d;

  logic tick_w;
  logic step_hit, sec_hit, last_sec;

  tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_w)
  );

  assign step_hit = (step_cnt_q == step_period(speed_q) - STEP_W'(1));
  assign sec_hit  = (sub_cnt_q == SUB_W'(TICKS_PER_SEC - 1));
  assign last_sec = sec_hit && (time_left_q == 8'd1);

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    step_cnt_d  = step_cnt_q;
    sub_cnt_d   = sub_cnt_q;
    speed_d     = speed_q;
    step_d      = 1'b0;
    done_d      = 1'b0;

    if (stop) begin
      state_d    = ST_IDLE;
      step_cnt_d = '0;
      sub_cnt_d  = '0;
    end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      speed_d     = speed;
      step_cnt_d  = '0;
      sub_cnt_d   = '0;
      time_left_d = game_len;
      if (game_len == 8'd0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (pause && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (pause && state_q == ST_PAUSE) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && tick_w) begin
      // A pause arriving on a tick wins, so the tick is simply not counted.
      if (step_hit) begin
        step_cnt_d = '0;
        speed_d    = speed;
      end else begin
        step_cnt_d = step_cnt_q + STEP_W'(1);
      end
      if (sec_hit) begin
        sub_cnt_d   = '0;
        time_left_d = time_left_q - 8'd1;
      end else begin
        sub_cnt_d = sub_cnt_q + SUB_W'(1);
      end
      if (last_sec) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        step_d = step_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      time_left_q <= '0;
      step_cnt_q  <= '0;
      sub_cnt_q   <= '0;
      speed_q     <= 2'b00;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      step_cnt_q  <= step_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      speed_q     <= speed_d;
      step_q      <= step_d;
      done_q      <= done_d;
    end
  end

  assign tick      = tick_w;
  assign step      = step_q;
  assign time_left = time_left_q;
  assign state     = state_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tempo_scheduler.sv
// Self-checking bench for tempo_scheduler with a fast divider; a cycle model
// feeds a scoreboard queue that is drained against the DUT every cycle.
module tb_tempo_scheduler;

  localparam int TD = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] speed = 2'b00;
  logic [7:0] game_len = 8'd0;
  logic       tick, step, done;
  logic [7:0] time_left;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b1;

  tempo_scheduler #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .speed     (speed),
    .game_len  (game_len),
    .tick      (tick),
    .step      (step),
    .time_left (time_left),
    .state     (state),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int period_of(input int s);
    case (s)
      0: return 50;
      1: return 25;
      2: return 10;
      default: return 5;
    endcase
  endfunction

  // Reference model: 0=idle 1=run 2=pause 3=done
  int m_st = 0, m_tl = 0, m_sc = 0, m_ss = 0, m_spd = 0, m_dcnt = 0;
  bit m_tick = 0, m_step = 0, m_done = 0;
  logic [12:0] exp_q[$];

  always @(posedge clk) begin
    bit tnow;
    if (!rst_n) begin
      m_st = 0; m_tl = 0; m_sc = 0; m_ss = 0; m_spd = 0; m_dcnt = 0;
      m_tick = 0; m_step = 0; m_done = 0;
    end else begin
      tnow = m_tick;
      m_step = 0;
      m_done = 0;
      if (stop) begin
        m_st = 0; m_sc = 0; m_ss = 0;
      end else if (start && (m_st == 0 || m_st == 3)) begin
        m_spd = speed; m_sc = 0; m_ss = 0; m_tl = game_len;
        if (game_len == 0) begin m_st = 3; m_done = 1; end
        else m_st = 1;
      end else if (pause && m_st == 1) begin
        m_st = 2;
      end else if (pause && m_st == 2) begin
        m_st = 1;
      end else if (m_st == 1 && tnow) begin
        bit sh;
        sh = (m_sc + 1 == period_of(m_spd));
        m_sc = sh ? 0 : m_sc + 1;
        if (sh) m_spd = speed;
        m_ss = m_ss + 1;
        if (m_ss == 100) begin
          m_ss = 0;
          m_tl = m_tl - 1;
        end
        if (m_ss == 0 && m_tl == 0) begin
          m_st = 3; m_done = 1;
        end else m_step = sh;
      end
      m_tick = (m_dcnt == TD - 1);
      m_dcnt = m_tick ? 0 : m_dcnt + 1;
    end
    exp_q.push_back({2'(m_st), 8'(m_tl), m_step, m_done, m_tick});
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (mon_en) chk("cyc", {19'd0, state, time_left, step, done, tick}, {19'd0, e});
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; cyc(); pause = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  initial begin
    int ticks, steps, n, dec_at, prev, gap_bad, tl;
    bit done_seen, found;

    cyc(3);
    chk("rst_state", state, 0);
    chk("rst_tl", time_left, 0);
    chk("rst_step", step, 0);
    chk("rst_tick", tick, 0);
    rst_n = 1'b1;

    ticks = 0; steps = 0;
    repeat (100) begin
      cyc();
      if (tick) ticks++;
      if (step) steps++;
    end
    chk("idle_ticks", ticks, 10);
    chk("idle_steps", steps, 0);
    chk("idle_state", state, 0);

    // Two-second game at the fastest speed
    game_len = 8'd2; speed = 2'b11;
    pulse_start();
    chk("g1_run", state, 1);
    chk("g1_tl_load", time_left, 2);
    n = 1; steps = 0; dec_at = -1; done_seen = 0; prev = -1; gap_bad = 0;
    while (!done_seen && n < 3000) begin
      cyc(); n++;
      if (step) begin
        steps++;
        if (prev >= 0 && n - prev != 50) gap_bad++;
        prev = n;
      end
      if (time_left == 8'd1 && dec_at < 0) dec_at = n;
      if (done) done_seen = 1;
    end
    chk("g1_done_seen", done_seen, 1);
    chk("g1_steps", steps, 39);
    chk("g1_gap", gap_bad, 0);
    chk("g1_dec_win", (dec_at >= 985 && dec_at <= 1010), 1);
    chk("g1_done_win", (n >= 1985 && n <= 2010), 1);
    chk("g1_state", state, 3);
    chk("g1_tl0", time_left, 0);
    cyc(20);
    chk("g1_done_hold", done, 0);

    // Pause freezes the game; restart from DONE
    game_len = 8'd3; speed = 2'b00;
    pulse_start();
    chk("g2_run", state, 1);
    cyc(430);
    pulse_pause();
    chk("p_state", state, 2);
    tl = time_left; steps = 0;
    repeat (300) begin
      cyc();
      if (step) steps++;
    end
    chk("p_tl", time_left, tl);
    chk("p_steps", steps, 0);
    pulse_start();
    chk("p_start_ign", state, 2);
    pulse_pause();
    chk("p_resume", state, 1);
    cyc(200);
    tl = time_left;
    pulse_stop();
    chk("stop_state", state, 0);
    chk("stop_tl", time_left, tl);

    // Simultaneous start/stop, then zero-length game
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("ss_idle", state, 0);
    game_len = 8'd0;
    pulse_start();
    chk("z_done", done, 1);
    chk("z_state", state, 3);
    cyc();
    chk("z_done_one", done, 0);
    pulse_pause();
    chk("z_pause_ign", state, 3);

    // Speed change mid-step
    game_len = 8'd5; speed = 2'b00;
    pulse_start();
    cyc(200);
    speed = 2'b11;
    n = 0; found = 0;
    while (!found && n < 600) begin
      cyc(); n++;
      if (step) found = 1;
    end
    chk("sp_first", (found && n >= 285 && n <= 310), 1);
    n = 0; found = 0;
    while (!found && n < 200) begin
      cyc(); n++;
      if (step) found = 1;
    end
    chk("sp_gap", n, 50);

    // Asynchronous reset mid-run
    cyc(37);
    chk("ar_pre", state, 1);
    @(posedge clk); #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ar_state", state, 0);
    chk("ar_tl", time_left, 0);
    chk("ar_step", step, 0);
    chk("ar_done", done, 0);
    chk("ar_tick", tick, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    mon_en = 1'b1;
    cyc(50);
    chk("ar_idle", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tempo_scheduler.md
TEMPO_SCHEDULER -- requirements
Module: tempo_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, meaning clk cycles per tick (100 Hz at 100 MHz); overridable for simulation.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, single-cycle pulse that loads and starts a game.
REQ-005 SHALL have port pause, input, 1, single-cycle pulse that toggles RUN/PAUSE.
REQ-006 SHALL have port stop, input, 1, single-cycle pulse that aborts to IDLE.
REQ-007 SHALL have port speed, input, 2, step period select: 00=50, 01=25, 10=10, 11=5 ticks.
REQ-008 SHALL have port game_len, input, 8, game length in seconds, sampled on an accepted start.
REQ-009 SHALL have port tick, output, 1, one-cycle pulse every TICK_DIV cycles.
REQ-010 SHALL have port step, output, 1, one-cycle pulse that advances falling tiles.
REQ-011 SHALL have port time_left, output, 8, remaining seconds.
REQ-012 SHALL have port state, output, 2, IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on entry to DONE.

Function
REQ-014 The tick divider SHALL count 0..TICK_DIV-1 continuously in every state and assert tick for the single cycle in which the count wraps to 0.
REQ-015 Accepted command priority SHALL be stop > start > pause when several are asserted in the same cycle.
REQ-016 In IDLE, start SHALL load time_left=game_len, latch speed, clear the step and sub-second counters, and enter RUN on the next edge.
REQ-017 If start is accepted with game_len=0, the FSM SHALL enter DONE directly and pulse done in that same transition.
REQ-018 In RUN, each tick SHALL increment the step counter and the sub-second counter; pause and tick SHALL not advance any other counter.
REQ-019 When the step counter reaches the latched period minus 1 on a tick, step SHALL pulse for one cycle, the counter SHALL wrap to 0, and speed SHALL be re-latched there, so speed changes apply only at step boundaries.
REQ-020 When the sub-second counter reaches 99 on a tick, it SHALL wrap to 0 and time_left SHALL decrement by 1.
REQ-021 A decrement of time_left from 1 to 0 SHALL move the FSM to DONE and pulse done; step SHALL be suppressed on that same tick.
REQ-022 In RUN, pause SHALL enter PAUSE; in PAUSE, pause SHALL return to RUN; all counters and time_left SHALL be frozen in PAUSE.
REQ-023 stop SHALL enter IDLE from any state, clear the step and sub-second counters, and leave time_left unchanged.
REQ-024 In DONE, start SHALL restart exactly as from IDLE, and pause SHALL be ignored.
REQ-025 start SHALL be ignored in RUN and in PAUSE.
REQ-026 step and done SHALL never assert outside RUN, except for the done pulse defined in REQ-017 and REQ-021.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, tick=0, step=0, done=0, time_left=0, all counters=0 and latched speed=00.
REQ-028 Reset assertion mid-game SHALL discard the game; after release the block SHALL wait in IDLE for a start pulse.

Structure
REQ-029 A shared package SHALL hold the state encoding, the speed-to-period table (50/25/10/5), and the ticks-per-second constant (100).
REQ-030 The divider SHALL be a sub-module tick_div (parameter TICK_DIV; ports clk, rst_n, tick); the FSM and counters SHALL be in tempo_scheduler.

Verification (TICK_DIV=10)
REQ-031 Reset, then idle for 100 cycles -> tick pulses every 10 cycles, step=0, state=0.
REQ-032 start with game_len=2 and speed=11 -> state=1, step every 50 cycles, time_left 2->1 after 1000 cycles, done pulses and state=3 after 2000 cycles, and only 39 steps are issued.
REQ-033 pause for 300 cycles in the middle of a game -> time_left and step phase are frozen, and the game resumes at the identical phase.
REQ-034 start and stop in the same cycle from IDLE -> remains IDLE; start with game_len=0 -> done pulse and state=3.
REQ-035 Change speed from 00 to 11 mid-step -> the current 50-tick step completes before 5-tick steps begin.
REQ-036 Assert rst_n low mid-RUN -> all outputs are 0 immediately, without waiting for a clock edge.
